alu_issue: RTL

- Execute-stage issue/retire wrapper directly around `alu`.
- Upstream: accepts one decoded integer instruction per handshake and builds the 4-bit ALU op and both operands.
- ALU side: drives the ALU for one cycle, then waits for its result. ADD/SUB takes 2 cycles; all other ops take 1.
- Downstream: holds the result with its destination register until writeback accepts it.

---
 rtl/alu_issue_if.sv | 58 +++++
 rtl/alu_issue.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/alu_issue_if.sv
// rtl/alu_issue_if.sv - upstream, ALU and writeback signal bundle for alu_issue
//
// Purpose: groups every non-clock/reset port of alu_issue.
// Modports:
//   slave  - seen by alu_issue (i_* inputs, o_* outputs)
//   master - seen by the driver of alu_issue (testbench / pipeline)
// Signals:
//   upstream : i_valid, o_ready, i_funct3, i_funct7_5, i_is_imm, i_force_add,
//              i_a_sel, i_rs1_val, i_rs2_val, i_imm, i_pc, i_rs1, i_rs2, i_rd
//   ALU      : o_alu_op, o_alu_a, o_alu_b, o_alu_valid, i_alu_out, i_alu_valid
//   writeback: o_wb_valid, i_wb_ready, o_wb_data, o_wb_rd
interface alu_issue_if #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
);
    logic            i_valid;
    logic            o_ready;
    logic [2:0]      i_funct3;
    logic            i_funct7_5;
    logic            i_is_imm;
    logic            i_force_add;
    logic [1:0]      i_a_sel;
    logic [XLEN-1:0] i_rs1_val;
    logic [XLEN-1:0] i_rs2_val;
    logic [XLEN-1:0] i_imm;
    logic [XLEN-1:0] i_pc;
    logic [RD_W-1:0] i_rs1;
    logic [RD_W-1:0] i_rs2;
    logic [RD_W-1:0] i_rd;

    logic [3:0]      o_alu_op;
    logic [XLEN-1:0] o_alu_a;
    logic [XLEN-1:0] o_alu_b;
    logic            o_alu_valid;
    logic [XLEN-1:0] i_alu_out;
    logic            i_alu_valid;

    logic            o_wb_valid;
    logic            i_wb_ready;
    logic [XLEN-1:0] o_wb_data;
    logic [RD_W-1:0] o_wb_rd;

    modport slave (
        input  i_valid, i_funct3, i_funct7_5, i_is_imm, i_force_add, i_a_sel,
               i_rs1_val, i_rs2_val, i_imm, i_pc, i_rs1, i_rs2, i_rd,
               i_alu_out, i_alu_valid, i_wb_ready,
        output o_ready, o_alu_op, o_alu_a, o_alu_b, o_alu_valid,
               o_wb_valid, o_wb_data, o_wb_rd
    );

    modport master (
        output i_valid, i_funct3, i_funct7_5, i_is_imm, i_force_add, i_a_sel,
               i_rs1_val, i_rs2_val, i_imm, i_pc, i_rs1, i_rs2, i_rd,
               i_alu_out, i_alu_valid, i_wb_ready,
        input  o_ready, o_alu_op, o_alu_a, o_alu_b, o_alu_valid,
               o_wb_valid, o_wb_data, o_wb_rd
    );
endinterface

// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - execute-stage issue/retire wrapper around the integer ALU
//
// Purpose: accepts one decoded RV32I ALU instruction, builds {sp, op} and the
// operands, strobes the ALU for one cycle, waits for its result and holds it
// with the destination index until writeback accepts it. One instruction in
// flight at a time.
// Ports:
//   i_clk   - clock, all state on the rising edge
//   i_rst_n - asynchronous active-low reset
//   bus     - alu_issue_if.slave (upstream, ALU and writeback signals)
// Optional feature: define ALU_ISSUE_FWD_EN to forward the most recently
// retired result into rs1/rs2 on accept.
module alu_issue #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    alu_issue_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next;

    logic            w_accept;
    logic            w_capture;
    logic            w_retire;
    logic [2:0]      w_op;
    logic            w_sp;
    logic [XLEN-1:0] w_rs1_eff;
    logic [XLEN-1:0] w_rs2_eff;
    logic [XLEN-1:0] w_a;
    logic [XLEN-1:0] w_b;

    logic [3:0]      r_alu_op;
    logic [XLEN-1:0] r_alu_a;
    logic [XLEN-1:0] r_alu_b;
    logic [XLEN-1:0] r_wb_data;
    logic [RD_W-1:0] r_wb_rd;

    assign w_accept  = (r_state == S_IDLE) && bus.i_valid;
    assign w_capture = (r_state == S_WAIT) && bus.i_alu_valid;
    assign w_retire  = (r_state == S_HOLD) && bus.i_wb_ready;

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and state-decoded outputs
    always_comb begin
        w_next          = r_state;
        bus.o_ready     = 1'b0;
        bus.o_alu_valid = 1'b0;
        bus.o_wb_valid  = 1'b0;
        case (r_state)
            S_IDLE: begin
                bus.o_ready = 1'b1;
                if (bus.i_valid) w_next = S_ISSUE;
            end
            S_ISSUE: begin
                bus.o_alu_valid = 1'b1;
                w_next          = S_WAIT;
            end
            S_WAIT: begin
                if (bus.i_alu_valid) w_next = S_HOLD;
            end
            S_HOLD: begin
                bus.o_wb_valid = 1'b1;
                if (bus.i_wb_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Op decode: sp selects SUB for the OP form of funct3=0 and SRA/SRAI for
    // funct3=5; ADDI ignores instr[30] since it is part of the immediate.
    always_comb begin
        w_op = bus.i_funct3;
        w_sp = 1'b0;
        if (bus.i_funct3 == 3'd5) begin
            w_sp = bus.i_funct7_5;
        end else if (bus.i_funct3 == 3'd0) begin
            w_sp = bus.i_funct7_5 & ~bus.i_is_imm;
        end
        if (bus.i_force_add) begin
            w_op = 3'd0;
            w_sp = 1'b0;
        end
    end

`ifdef ALU_ISSUE_FWD_EN
    logic [RD_W-1:0] r_last_rd;
    logic [XLEN-1:0] r_last_data;

    // Remember the last retired result; x0 is never forwarded.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last_rd   <= '0;
            r_last_data <= '0;
        end else if (w_retire) begin
            r_last_rd   <= r_wb_rd;
            r_last_data <= r_wb_data;
        end
    end

    always_comb begin
        w_rs1_eff = bus.i_rs1_val;
        w_rs2_eff = bus.i_rs2_val;
        if ((r_last_rd != '0) && (bus.i_rs1 == r_last_rd)) w_rs1_eff = r_last_data;
        if ((r_last_rd != '0) && (bus.i_rs2 == r_last_rd)) w_rs2_eff = r_last_data;
    end
`else
    logic w_unused_fwd_idx;
    assign w_unused_fwd_idx = ^{bus.i_rs1, bus.i_rs2};
    assign w_rs1_eff = bus.i_rs1_val;
    assign w_rs2_eff = bus.i_rs2_val;
`endif

    // Operand selection; pc feeds AUIPC, zero feeds LUI.
    always_comb begin
        case (bus.i_a_sel)
            2'd0:    w_a = w_rs1_eff;
            2'd1:    w_a = bus.i_pc;
            default: w_a = '0;
        endcase
        w_b = (bus.i_is_imm | bus.i_force_add) ? bus.i_imm : w_rs2_eff;
    end

    // Datapath: ALU inputs load only on accept so they stay stable until the
    // next instruction; result is captured only in WAIT.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_alu_op  <= '0;
            r_alu_a   <= '0;
            r_alu_b   <= '0;
            r_wb_data <= '0;
            r_wb_rd   <= '0;
        end else begin
            if (w_accept) begin
                r_alu_op <= {w_sp, w_op};
                r_alu_a  <= w_a;
                r_alu_b  <= w_b;
                r_wb_rd  <= bus.i_rd;
            end
            if (w_capture) begin
                r_wb_data <= bus.i_alu_out;
            end
        end
    end

    assign bus.o_alu_op  = r_alu_op;
    assign bus.o_alu_a   = r_alu_a;
    assign bus.o_alu_b   = r_alu_b;
    assign bus.o_wb_data = r_wb_data;
    assign bus.o_wb_rd   = r_wb_rd;
endmodule
